control_unit_fsm: RTL and testbench



---
 rtl/control_unit_fsm.sv | 208 ++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm.sv
// Multicycle control unit for the RV64 datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional macro BRANCH_EXT_EN adds bne/blt/bge decode to the branch path.
//
// state     | meaning
// RST       | post-reset idle, all outputs 0
// FETCH     | instruction memory wait (MEM_WAIT_CYCLES)
// IR_LOAD   | capture instruction register
// DECODE    | operand capture, dispatch on opcode
// EXEC_R    | register-register ALU op and writeback
// EXEC_I    | addi and writeback
// ADDR      | effective address for ld/sd
// MEM_RD    | data memory wait, memory-data register load on last cycle
// WB_LOAD   | write loaded data to register bank
// MEM_WR    | single-cycle data memory write
// BRANCH    | compare operands, resolve taken/not taken
// BR_TAKE   | PC <= PC + branch immediate
// WB_LUI    | write U immediate to register bank
// NEXT_PC   | PC <= PC + 4
// HALT      | illegal instruction, parked until reset
module control_unit_fsm #(
  parameter int MEM_WAIT_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] Instr6_0,
  input  logic [2:0] Instr14_12,
  input  logic       Instr30,
  input  logic       igual,
  input  logic       menor,
  output logic       PC_regwrite,
  output logic       load_ir,
  output logic       bancoRegisters_write,
  output logic       Register_Memory_regwrite,
  output logic       DataMemory_wr,
  output logic [2:0] Mux64_Ula_A_Seletor,
  output logic [2:0] Mux64_Ula_B_Seletor,
  output logic [3:0] Seletor,
  output logic [1:0] imm_sel,
  output logic [1:0] wb_sel,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_IR_LOAD, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_WB_LOAD, S_MEM_WR, S_BRANCH, S_BR_TAKE, S_WB_LUI, S_NEXT_PC, S_HALT
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] wait_cnt;
  logic       wait_done;
  logic       r_ok, br_ok, br_take;
  logic [3:0] r_alu;

  assign wait_done = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_RST;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      // counter only runs in the two wait states and is zero on every entry
      if ((state == S_FETCH || state == S_MEM_RD) && !wait_done)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= 4'd0;
    end
  end

  always_comb begin
    r_ok  = (Instr14_12 == 3'b000) ||
            (!Instr30 && (Instr14_12 == 3'b111 || Instr14_12 == 3'b110));
    case (Instr14_12)
      3'b000:  r_alu = Instr30 ? 4'd2 : 4'd1;
      3'b111:  r_alu = 4'd3;
      3'b110:  r_alu = 4'd4;
      default: r_alu = 4'd0;
    endcase
  end

`ifdef BRANCH_EXT_EN
  always_comb begin
    br_ok   = 1'b1;
    br_take = 1'b0;
    case (Instr14_12)
      3'b000:  br_take = igual;
      3'b001:  br_take = !igual;
      3'b100:  br_take = menor;
      3'b101:  br_take = !menor;
      default: br_ok   = 1'b0;
    endcase
  end
`else
  logic br_unused;
  assign br_unused = menor;
  assign br_ok     = (Instr14_12 == 3'b000);
  assign br_take   = igual;
`endif

  always_comb begin
    state_nx                 = state;
    PC_regwrite              = 1'b0;
    load_ir                  = 1'b0;
    bancoRegisters_write     = 1'b0;
    Register_Memory_regwrite = 1'b0;
    DataMemory_wr            = 1'b0;
    Mux64_Ula_A_Seletor      = 3'd0;
    Mux64_Ula_B_Seletor      = 3'd0;
    Seletor                  = 4'd0;
    imm_sel                  = 2'd0;
    wb_sel                   = 2'd0;
    halted                   = 1'b0;
    case (state)
      S_RST:     state_nx = S_FETCH;
      S_FETCH:   if (wait_done) state_nx = S_IR_LOAD;
      S_IR_LOAD: begin
        load_ir  = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        case (Instr6_0)
          OP_R:    state_nx = r_ok ? S_EXEC_R : S_HALT;
          OP_I:    state_nx = (Instr14_12 == 3'b000) ? S_EXEC_I : S_HALT;
          OP_LD,
          OP_SD:   state_nx = (Instr14_12 == 3'b011) ? S_ADDR : S_HALT;
          OP_BR:   state_nx = br_ok ? S_BRANCH : S_HALT;
          OP_LUI:  state_nx = S_WB_LUI;
          default: state_nx = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        Mux64_Ula_A_Seletor  = 3'd1;
        Seletor              = r_alu;
        bancoRegisters_write = 1'b1;
        state_nx             = S_NEXT_PC;
      end
      S_EXEC_I: begin
        Mux64_Ula_A_Seletor  = 3'd1;
        Mux64_Ula_B_Seletor  = 3'd2;
        Seletor              = 4'd1;
        bancoRegisters_write = 1'b1;
        state_nx             = S_NEXT_PC;
      end
      S_ADDR: begin
        Mux64_Ula_A_Seletor = 3'd1;
        Mux64_Ula_B_Seletor = 3'd2;
        Seletor             = 4'd1;
        imm_sel             = (Instr6_0 == OP_SD) ? 2'd1 : 2'd0;
        state_nx            = (Instr6_0 == OP_SD) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        Mux64_Ula_A_Seletor      = 3'd1;
        Mux64_Ula_B_Seletor      = 3'd2;
        Seletor                  = 4'd1;
        Register_Memory_regwrite = wait_done;
        if (wait_done) state_nx  = S_WB_LOAD;
      end
      S_WB_LOAD: begin
        bancoRegisters_write = 1'b1;
        wb_sel               = 2'd1;
        state_nx             = S_NEXT_PC;
      end
      S_MEM_WR: begin
        Mux64_Ula_A_Seletor = 3'd1;
        Mux64_Ula_B_Seletor = 3'd2;
        Seletor             = 4'd1;
        imm_sel             = 2'd1;
        DataMemory_wr       = 1'b1;
        state_nx            = S_NEXT_PC;
      end
      S_BRANCH: begin
        Mux64_Ula_A_Seletor = 3'd1;
        Seletor             = 4'd2;
        state_nx            = br_take ? S_BR_TAKE : S_NEXT_PC;
      end
      S_BR_TAKE: begin
        Mux64_Ula_B_Seletor = 3'd2;
        Seletor             = 4'd1;
        imm_sel             = 2'd2;
        PC_regwrite         = 1'b1;
        state_nx            = S_FETCH;
      end
      S_WB_LUI: begin
        imm_sel              = 2'd3;
        wb_sel               = 2'd2;
        bancoRegisters_write = 1'b1;
        state_nx             = S_NEXT_PC;
      end
      S_NEXT_PC: begin
        Mux64_Ula_B_Seletor = 3'd1;
        Seletor             = 4'd1;
        PC_regwrite         = 1'b1;
        state_nx            = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nx = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench for control_unit_fsm: per-instruction expected output streams are queued
// from an instruction-level model and checked cycle by cycle by an independent monitor.
`timescale 1ns/1ps
module tb_control_unit_fsm;
  localparam int N = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic       i30 = 1'b0, igual = 1'b0, menor = 1'b0;
  logic       PC_regwrite, load_ir, bancoRegisters_write, Register_Memory_regwrite, DataMemory_wr;
  logic [2:0] a_sel, b_sel;
  logic [3:0] alu_sel;
  logic [1:0] imm_sel, wb_sel;
  logic       halted;

  always #5 clock = ~clock;

  control_unit_fsm #(.MEM_WAIT_CYCLES(N)) dut (
    .clock(clock), .reset(reset), .Instr6_0(op), .Instr14_12(f3), .Instr30(i30),
    .igual(igual), .menor(menor), .PC_regwrite(PC_regwrite), .load_ir(load_ir),
    .bancoRegisters_write(bancoRegisters_write),
    .Register_Memory_regwrite(Register_Memory_regwrite), .DataMemory_wr(DataMemory_wr),
    .Mux64_Ula_A_Seletor(a_sel), .Mux64_Ula_B_Seletor(b_sel), .Seletor(alu_sel),
    .imm_sel(imm_sel), .wb_sel(wb_sel), .halted(halted)
  );

  wire [19:0] act = {PC_regwrite, load_ir, bancoRegisters_write, Register_Memory_regwrite,
                     DataMemory_wr, a_sel, b_sel, alu_sel, imm_sel, wb_sel, halted};

  typedef struct {logic [19:0] v; int id;} exp_t;
  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0, instr_id = 0;

  function automatic logic [19:0] mk(input bit pc, ir, rf, rm, dm,
                                     input int a, b, s, imm, wb, input bit h);
    return {pc, ir, rf, rm, dm, 3'(a), 3'(b), 4'(s), 2'(imm), 2'(wb), h};
  endfunction

  function automatic void br_model(input logic [2:0] fn, input bit eq, lt,
                                   output bit ok, output bit tk);
    ok = 1'b1;
    tk = 1'b0;
`ifdef BRANCH_EXT_EN
    case (fn)
      3'd0:    tk = eq;
      3'd1:    tk = !eq;
      3'd4:    tk = lt;
      3'd5:    tk = !lt;
      default: ok = 1'b0;
    endcase
`else
    ok = (fn == 3'd0);
    tk = eq;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [19:0] v);
    exp_q.push_back('{v: v, id: instr_id});
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    instr_id++;
    repeat (cyc) begin
      step();
      push(20'd0);
    end
    reset = 1'b0;
  endtask

  // Issue one instruction: queue the expected per-cycle outputs, then let it run (optionally cut short).
  task automatic issue(input logic [6:0] o, input logic [2:0] fn, input bit b30, eq, lt,
                       input int max_cyc, output bit did_halt);
    logic [19:0] seq[$];
    logic [19:0] npc, hlt;
    bit ok, tk;
    int n, alu;
    npc = mk(1,0,0,0,0, 0,1,1,0,0, 0);
    hlt = mk(0,0,0,0,0, 0,0,0,0,0, 1);
    instr_id++;
    op = o; f3 = fn; i30 = b30; igual = eq; menor = lt;
    did_halt = 1'b0;
    repeat (N) seq.push_back(20'd0);
    seq.push_back(mk(0,1,0,0,0, 0,0,0,0,0, 0));
    seq.push_back(20'd0);
    case (o)
      7'b0110011: begin
        ok  = (fn == 3'd0) || (!b30 && (fn == 3'd7 || fn == 3'd6));
        alu = (fn == 3'd0) ? (b30 ? 2 : 1) : (fn == 3'd7 ? 3 : 4);
        if (ok) begin seq.push_back(mk(0,0,1,0,0, 1,0,alu,0,0, 0)); seq.push_back(npc); end
        else did_halt = 1'b1;
      end
      7'b0010011:
        if (fn == 3'd0) begin seq.push_back(mk(0,0,1,0,0, 1,2,1,0,0, 0)); seq.push_back(npc); end
        else did_halt = 1'b1;
      7'b0000011:
        if (fn == 3'd3) begin
          repeat (N) seq.push_back(mk(0,0,0,0,0, 1,2,1,0,0, 0));
          seq.push_back(mk(0,0,0,0,0, 1,2,1,0,0, 0));
          seq[seq.size()-1] = mk(0,0,0,1,0, 1,2,1,0,0, 0);
          seq.push_back(mk(0,0,1,0,0, 0,0,0,0,1, 0));
          seq.push_back(npc);
        end else did_halt = 1'b1;
      7'b0100011:
        if (fn == 3'd3) begin
          seq.push_back(mk(0,0,0,0,0, 1,2,1,1,0, 0));
          seq.push_back(mk(0,0,0,0,1, 1,2,1,1,0, 0));
          seq.push_back(npc);
        end else did_halt = 1'b1;
      7'b1100011: begin
        br_model(fn, eq, lt, ok, tk);
        if (ok) begin
          seq.push_back(mk(0,0,0,0,0, 1,0,2,0,0, 0));
          seq.push_back(tk ? mk(1,0,0,0,0, 0,2,1,2,0, 0) : npc);
        end else did_halt = 1'b1;
      end
      7'b0110111: begin seq.push_back(mk(0,0,1,0,0, 0,0,0,3,2, 0)); seq.push_back(npc); end
      default: did_halt = 1'b1;
    endcase
    if (did_halt) repeat (20) seq.push_back(hlt);
    n = (seq.size() < max_cyc) ? seq.size() : max_cyc;
    for (int i = 0; i < n; i++) push(seq[i]);
    repeat (n) step();
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL outputs instr%0d t=%0t got %h expected %h", e.id, $time, act, e.v);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    int r;
    logic [6:0] o;
    logic [2:0] fn;
    bit b30;
    do_reset(2);
    issue(7'b0110011, 3'd0, 1'b0, 0, 0, 1000, h);              // add
    issue(7'b0000011, 3'd3, 1'b0, 0, 0, N + 4, h);             // ld cut in MEM_RD
    do_reset(3);
    issue(7'b0000011, 3'd3, 1'b0, 0, 0, 1000, h);              // ld full
    issue(7'b0100011, 3'd3, 1'b0, 0, 0, 1000, h);              // sd
    issue(7'b1100011, 3'd0, 1'b0, 1, 0, 1000, h);              // beq taken
    issue(7'b1100011, 3'd0, 1'b0, 0, 1, 1000, h);              // beq not taken
    issue(7'b0110111, 3'd5, 1'b1, 0, 0, 1000, h);              // lui
    issue(7'b1100011, 3'd1, 1'b0, 0, 0, 1000, h);              // bne, igual=0
    if (h) do_reset(2);
    issue(7'b1111111, 3'd0, 1'b0, 0, 0, 1000, h);              // illegal
    do_reset(2);
    for (int k = 0; k < 80; k++) begin
      r   = $urandom_range(0, 9);
      fn  = 3'($urandom_range(0, 7));
      b30 = 1'b0;
      case (r)
        0, 1: begin
          o  = 7'b0110011;
          r  = $urandom_range(0, 2);
          fn = (r == 0) ? 3'd0 : (r == 1 ? 3'd7 : 3'd6);
          b30 = (fn == 3'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        2: begin o = 7'b0010011; fn = 3'd0; end
        3: begin o = 7'b0000011; fn = 3'd3; end
        4: begin o = 7'b0100011; fn = 3'd3; end
        5, 6: begin
          o = 7'b1100011;
          r = $urandom_range(0, 5);
          fn = (r < 2) ? 3'd0 : (r == 2 ? 3'd1 : (r == 3 ? 3'd4 : (r == 4 ? 3'd5 : 3'd2)));
        end
        7: o = 7'b0110111;
        8: o = 7'($urandom_range(0, 127));
        default: begin
          r = $urandom_range(0, 3);
          o = (r == 0) ? 7'b0010011 : (r == 1 ? 7'b0000011 : (r == 2 ? 7'b0100011 : 7'b0110011));
        end
      endcase
      issue(o, fn, b30, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1000, h);
      if (h) do_reset(1 + $urandom_range(0, 2));
    end
    step();
    step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain leftover %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
